alu_issue_decoder: RTL
======================

Name: alu_issue_decoder

Overview:
- Front end of the ALU interface. Accepts 32-bit ALU instructions over a valid/ready handshake and decodes them into the ALU control bundle: opcode, source select, immediate, shift amount, plus register addresses.
- Registers the bundle toward the execute stage over a second valid/ready handshake.
- 2-entry elastic buffer (output register + skid register) gives full throughput under back-pressure.

Parameters:
- COUNT_W, 16, width of the issued-instruction counter.
- SHAMT_W, 5, number of immediate bits used as the shift amount.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  upstream instruction valid.
- instr_ready  out  1  decoder can accept.
- instr  in  32  encoding: [31:28] op, [27] imm_sel, [26:22] rd, [21:17] rs1, [16:12] rs2, [11:0] imm12.
- trap_clear  in  1  clears trap state (used only with DECODE_TRAP_EN).
- issue_valid  out  1  decoded bundle valid.
- issue_ready  in  1  execute stage accepts bundle.
- alu_opcode  out  4  ADD=0 SUB=1 MUL=2 AND=3 OR=4 NOT=5 NOR=6 NAND=7 XOR=8 XNOR=9 INC=10 DEC=11 SHL=12 SHR=13.
- alu_src_sel  out  1  0 = register B, 1 = immediate.
- alu_immediate_out  out  32  extended immediate.
- shift_amt  out  32  shift amount.
- rd_addr, rs1_addr, rs2_addr  out  5 each  register addresses.
- wb_hi_en  out  1  1 for MUL: upper 32 result bits are meaningful.
- illegal_op  out  1  illegal-opcode indication.
- issue_count  out  COUNT_W  bundles issued (wraps).

Behaviour:
- Reset: issue_valid=0, skid empty, instr_ready=1 on the first cycle after rst deasserts, illegal_op=0, issue_count=0. All bundle outputs are 0. Reset mid-transfer discards both buffered entries.
- Handshake: a transfer occurs when valid&ready are both high on a clock edge.
  - issue_valid and bundle must not change while issue_valid=1 and issue_ready=0.
  - instr_ready is registered: it equals ~skid_full (no combinational path from issue_ready).
- Latency: 1 cycle from accept to issue_valid. Throughput: 1 per cycle when issue_ready=1.
- Buffering:
  - Accept while the output register is empty or draining: the new bundle goes to the output register.
  - Accept while the output is stalled: the new bundle goes to the skid register.
  - When the output drains, the skid entry moves to the output and instr_ready returns to 1.
  - Program order is always preserved.
- Decode:
  - ADD/SUB/MUL: alu_src_sel=imm_sel; immediate = sign-extended imm12.
  - AND/OR/NOR/NAND/XOR/XNOR: alu_src_sel=imm_sel; immediate = zero-extended imm12.
  - NOT/INC/DEC: alu_src_sel=0; immediate=0.
  - SHL/SHR: alu_src_sel=0; immediate=0; shift_amt = zero-extended imm12[SHAMT_W-1:0].
  - All non-shift ops: shift_amt=0.
  - wb_hi_en=1 only for MUL.
- Illegal: op 14 or 15.
- issue_count increments on each issue handshake; wraps from all-ones to 0.
- Simultaneous accept and issue with the skid empty: the output register reloads directly with no bubble.

Optional Feature:
- Macro: DECODE_TRAP_EN.
- With the macro:
  - An illegal op is accepted but not issued.
  - illegal_op is set sticky, and instr_ready is held 0 after the buffered entries drain.
  - trap_clear=1 clears illegal_op; instr_ready returns to 1 on the next cycle.
- Without the macro:
  - An illegal op is accepted and dropped (not issued).
  - illegal_op pulses high for exactly 1 cycle.
  - trap_clear is ignored.

Decomposition:
- Shared package alu_pkg: 4-bit opcode enum/localparams (values above), instruction field bit positions, ILLEGAL opcode predicate.
- This package is also to be used by the ALU.
- One sub-module: alu_issue_skid, a generic 2-entry valid/ready elastic buffer of width parameter W.
- The decode function is combinational and sits in front of the skid module.

Test Plan:
- ADD immediate, instr=0x08C20FFF, issue_ready=1 → next cycle issue_valid=1, alu_opcode=0, alu_src_sel=1, alu_immediate_out=0xFFFFFFFF, rd=3, rs1=1, issue_count=1.
- AND immediate, instr=0x38C20FFF → alu_opcode=3, alu_src_sel=1, alu_immediate_out=0x00000FFF, wb_hi_en=0.
- SHL with imm_sel=1, instr=0xC8C20025 → alu_opcode=12, alu_src_sel=0, shift_amt=0x00000005, alu_immediate_out=0.
- Back-pressure: issue_ready=0, offer 3 back-to-back instrs A, B, C → A and B accepted, instr_ready=0 while C is offered, bundle A held stable. Raise issue_ready → A, B, C issue in order, and issue_count advances by 3.
- Illegal instr=0xF0000000:
  - Without the macro: no issue, illegal_op high for 1 cycle.
  - With DECODE_TRAP_EN: illegal_op sticky, instr_ready stays 0 until trap_clear pulses.
- Assert rst with both entries full → next cycle issue_valid=0, instr_ready=1, issue_count=0; the held bundle is never issued.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, instruction field positions, issue bundle.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_NAND = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_XNOR = 4'd9,
    ALU_INC  = 4'd10,
    ALU_DEC  = 4'd11,
    ALU_SHL  = 4'd12,
    ALU_SHR  = 4'd13
  } alu_op_e;

  // Instruction field bit positions
  localparam int OP_HI      = 31;
  localparam int OP_LO      = 28;
  localparam int IMM_SEL_B  = 27;
  localparam int RD_HI      = 26;
  localparam int RD_LO      = 22;
  localparam int RS1_HI     = 21;
  localparam int RS1_LO     = 17;
  localparam int RS2_HI     = 16;
  localparam int RS2_LO     = 12;
  localparam int IMM_HI     = 11;
  localparam int IMM_LO     = 0;

  // Decoded control bundle handed to the execute stage
  typedef struct packed {
    alu_op_e     op;
    logic        src_sel;
    logic [31:0] imm;
    logic [31:0] shamt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wb_hi_en;
  } alu_issue_t;

  // Encodings 14 and 15 have no ALU operation behind them
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= 4'd14);
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Generic 2-entry valid/ready elastic buffer (output register + skid register).
// Latency: 1 cycle in_dat -> out_dat; full throughput when out_rdy is high.
// Backpressure: in_rdy is registered (~skid full); skid absorbs one beat while output stalls.
module alu_issue_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         sk_vld;
  logic [W-1:0] sk_dat;
  logic         in_fire;
  logic         out_open;
  logic         sk_vld_nxt;

  assign in_fire  = in_vld & in_rdy;
  // Output register can take a new beat when empty or being drained this cycle
  assign out_open = ~out_vld | out_rdy;

  // Skid occupancy next cycle; in_fire cannot coincide with a full skid since in_rdy = ~sk_vld
  always_comb begin
    sk_vld_nxt = sk_vld;
    if (out_open) begin
      sk_vld_nxt = 1'b0;
    end else if (in_fire) begin
      sk_vld_nxt = 1'b1;
    end
  end

  // Output/skid registers: skid drains first to keep program order
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      sk_vld  <= 1'b0;
      sk_dat  <= '0;
      in_rdy  <= 1'b1;
    end else begin
      sk_vld <= sk_vld_nxt;
      in_rdy <= ~sk_vld_nxt;
      if (out_open) begin
        if (sk_vld) begin
          out_vld <= 1'b1;
          out_dat <= sk_dat;
        end else if (in_fire) begin
          out_vld <= 1'b1;
          out_dat <= in_dat;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (in_fire) begin
        sk_dat <= in_dat;
      end
    end
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// ALU issue front end: decodes 32-bit instructions into the ALU control bundle. Optional macro: DECODE_TRAP_EN.
// Latency: 1 cycle accept -> issue_valid; 1 bundle/cycle when issue_ready is high.
// Backpressure: 2-entry skid; instr_ready registered (no path from issue_ready); illegal ops never issue.
module alu_issue_decoder
  import alu_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  input  logic               trap_clear,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         alu_opcode,
  output logic               alu_src_sel,
  output logic [31:0]        alu_immediate_out,
  output logic [31:0]        shift_amt,
  output logic [4:0]         rd_addr,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  output logic               wb_hi_en,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] issue_count
);

  localparam int          W          = $bits(alu_issue_t);
  localparam logic [31:0] SHAMT_MASK = (32'd1 << SHAMT_W) - 32'd1;

  logic [3:0]  op_raw;
  logic [11:0] imm12;
  logic        op_illegal;
  logic        skid_in_rdy;
  logic        push_vld;
  logic        accept_illegal;
  logic        illegal_q;
  alu_issue_t  dec;
  alu_issue_t  issue_q;
  logic        unused_trap_clear;

  assign op_raw     = instr[OP_HI:OP_LO];
  assign imm12      = instr[IMM_HI:IMM_LO];
  assign op_illegal = is_illegal_op(op_raw);

  // Combinational decode of the offered instruction into the control bundle
  always_comb begin
    dec          = '0;
    dec.op       = alu_op_e'(op_raw);
    dec.rd       = instr[RD_HI:RD_LO];
    dec.rs1      = instr[RS1_HI:RS1_LO];
    dec.rs2      = instr[RS2_HI:RS2_LO];
    case (alu_op_e'(op_raw))
      ALU_ADD, ALU_SUB, ALU_MUL: begin
        dec.src_sel  = instr[IMM_SEL_B];
        dec.imm      = {{20{imm12[11]}}, imm12};
        dec.wb_hi_en = (alu_op_e'(op_raw) == ALU_MUL);
      end
      ALU_AND, ALU_OR, ALU_NOR, ALU_NAND, ALU_XOR, ALU_XNOR: begin
        dec.src_sel = instr[IMM_SEL_B];
        dec.imm     = {20'd0, imm12};
      end
      ALU_SHL, ALU_SHR: begin
        dec.shamt = {20'd0, imm12} & SHAMT_MASK;
      end
      default: begin
        // NOT/INC/DEC use register operands only; illegal encodings never reach the buffer
        dec.src_sel = 1'b0;
      end
    endcase
  end

  assign push_vld       = instr_valid & instr_ready & ~op_illegal;
  assign accept_illegal = instr_valid & instr_ready & op_illegal;

  alu_issue_skid #(
    .W (W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (push_vld),
    .in_rdy  (skid_in_rdy),
    .in_dat  (dec),
    .out_vld (issue_valid),
    .out_rdy (issue_ready),
    .out_dat (issue_q)
  );

`ifdef DECODE_TRAP_EN
  // Sticky trap: set on an accepted illegal op, cleared only by trap_clear
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (accept_illegal) begin
      illegal_q <= 1'b1;
    end else if (trap_clear) begin
      illegal_q <= 1'b0;
    end
  end

  // Both terms are registers, so issue_ready still has no path to instr_ready
  assign instr_ready       = skid_in_rdy & ~illegal_q;
  assign unused_trap_clear = 1'b0;
`else
  // One-cycle pulse per dropped illegal op
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept_illegal;
    end
  end

  assign instr_ready       = skid_in_rdy;
  assign unused_trap_clear = trap_clear;
`endif

  // Count completed issue handshakes; wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_count <= '0;
    end else if (issue_valid && issue_ready) begin
      issue_count <= issue_count + COUNT_W'(1);
    end
  end

  assign illegal_op        = illegal_q;
  assign alu_opcode        = issue_q.op;
  assign alu_src_sel       = issue_q.src_sel;
  assign alu_immediate_out = issue_q.imm;
  assign shift_amt         = issue_q.shamt;
  assign rd_addr           = issue_q.rd;
  assign rs1_addr          = issue_q.rs1;
  assign rs2_addr          = issue_q.rs2;
  assign wb_hi_en          = issue_q.wb_hi_en;

endmodule
